// File: rtl/bus_pkg.sv
// Shared definitions for the system bus interconnect: FSM states,
// master identifiers and the default WAIT-cycle timeout.
package bus_pkg;

    localparam int AW              = 32;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bus_state_t;

    typedef enum logic {
        MID_DATA  = 1'b0,
        MID_FETCH = 1'b1
    } master_id_t;

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational address decoder: slave k matches when
// (addr & mask[k]) == base[k]; the lowest matching index wins.
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int                          NUM_SLAVES = 8,
    parameter logic [NUM_SLAVES*AW-1:0]    SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*AW-1:0]    SLAVE_MASK = '0,
    parameter int                          IW         = $clog2(NUM_SLAVES)
) (
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    logic [NUM_SLAVES-1:0] match;

    // Per-slave match terms, evaluated in parallel.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign match[gi] = ((addr & SLAVE_MASK[gi*AW +: AW]) == SLAVE_BASE[gi*AW +: AW]);
        end
    endgenerate

    // Priority encode, scanning downwards so the lowest index is written last.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit = 1'b1;
                idx = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sys_bus_interconnect.sv
// Two-master (data + fetch) to N-slave bus interconnect with round-robin
// arbitration, registered slave fields, per-transaction timeout and
// error completion for unmapped addresses.
module sys_bus_interconnect
    import bus_pkg::*;
#(
    parameter int                          NUM_SLAVES = 8,
    parameter int                          DW         = 32,
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0]    SLAVE_MASK = '0,
    parameter int                          TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [31:0]              d_addr,
    input  logic [DW-1:0]            d_wdata,
    input  logic [DW/8-1:0]          d_be,
    output logic [DW-1:0]            d_rdata,
    output logic                     d_ready,
    output logic                     d_err,
    input  logic                     i_req,
    input  logic [31:0]              i_addr,
    output logic [DW-1:0]            i_rdata,
    output logic                     i_ready,
    output logic                     i_err,
    output logic [NUM_SLAVES-1:0]    s_req,
    output logic                     s_we,
    output logic [31:0]              s_addr,
    output logic [DW-1:0]            s_wdata,
    output logic [DW/8-1:0]          s_be,
    input  logic [NUM_SLAVES*DW-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready
);

    localparam int          IW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int          BW      = DW / 8;
    localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    bus_state_t             state_reg;
    master_id_t             mid_reg;
    master_id_t             last_grant_reg;
    logic [IW-1:0]          idx_reg;
    logic [31:0]            cnt_reg;
    logic [NUM_SLAVES-1:0]  s_req_reg;
    logic                   s_we_reg;
    logic [31:0]            s_addr_reg;
    logic [DW-1:0]          s_wdata_reg;
    logic [BW-1:0]          s_be_reg;
    logic [DW-1:0]          d_rdata_reg, i_rdata_reg;
    logic                   d_ready_reg, d_err_reg, i_ready_reg, i_err_reg;

    logic                   grant_fetch;
    logic [31:0]            sel_addr;
    logic                   dec_hit;
    logic [IW-1:0]          dec_idx;
    logic [DW-1:0]          rdata_arr [NUM_SLAVES];
    logic                   done_fire, done_err, done_fetch;
    logic [DW-1:0]          done_data;

    // Unpack the concatenated slave read-data bus.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
            assign rdata_arr[gi] = s_rdata[gi*DW +: DW];
        end
    endgenerate

    // Round-robin: fetch wins only if alone or if data was granted last.
    assign grant_fetch = i_req && (!d_req || (last_grant_reg == MID_DATA));
    assign sel_addr    = grant_fetch ? i_addr : d_addr;

    bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .IW         (IW)
    ) u_dec (
        .addr (sel_addr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Work out whether a response completes this cycle and with what payload.
    always_comb begin
        done_fire  = 1'b0;
        done_err   = 1'b0;
        done_data  = '0;
        done_fetch = (mid_reg == MID_FETCH);
        case (state_reg)
            ST_IDLE: begin
                if ((d_req || i_req) && !dec_hit) begin
                    done_fire  = 1'b1;
                    done_err   = 1'b1;
                    done_fetch = grant_fetch;
                end
            end
            ST_WAIT: begin
                if (s_ready[idx_reg]) begin
                    done_fire = 1'b1;
                    done_data = rdata_arr[idx_reg];
                end else if (cnt_reg >= TO_LAST) begin
                    done_fire = 1'b1;
                    done_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Transaction FSM with all outputs registered; ready is a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            mid_reg        <= MID_DATA;
            last_grant_reg <= MID_FETCH;
            idx_reg        <= '0;
            cnt_reg        <= '0;
            s_req_reg      <= '0;
            s_we_reg       <= 1'b0;
            s_addr_reg     <= '0;
            s_wdata_reg    <= '0;
            s_be_reg       <= '0;
            d_rdata_reg    <= '0;
            d_ready_reg    <= 1'b0;
            d_err_reg      <= 1'b0;
            i_rdata_reg    <= '0;
            i_ready_reg    <= 1'b0;
            i_err_reg      <= 1'b0;
        end else begin
            d_ready_reg <= 1'b0;
            i_ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (d_req || i_req) begin
                        mid_reg        <= grant_fetch ? MID_FETCH : MID_DATA;
                        last_grant_reg <= grant_fetch ? MID_FETCH : MID_DATA;
                        idx_reg        <= dec_idx;
                        cnt_reg        <= '0;
                        s_addr_reg     <= sel_addr;
                        s_we_reg       <= grant_fetch ? 1'b0 : d_we;
                        s_wdata_reg    <= grant_fetch ? '0 : d_wdata;
                        s_be_reg       <= grant_fetch ? '1 : d_be;
                        if (dec_hit) begin
                            s_req_reg <= {{(NUM_SLAVES-1){1'b0}}, 1'b1} << dec_idx;
                            state_reg <= ST_WAIT;
                        end else begin
                            state_reg <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (done_fire) begin
                        s_req_reg <= '0;
                        state_reg <= ST_RESP;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
            if (done_fire) begin
                if (done_fetch) begin
                    i_ready_reg <= 1'b1;
                    i_err_reg   <= done_err;
                    i_rdata_reg <= done_data;
                end else begin
                    d_ready_reg <= 1'b1;
                    d_err_reg   <= done_err;
                    d_rdata_reg <= done_data;
                end
            end
        end
    end

    assign s_req   = s_req_reg;
    assign s_we    = s_we_reg;
    assign s_addr  = s_addr_reg;
    assign s_wdata = s_wdata_reg;
    assign s_be    = s_be_reg;
    assign d_rdata = d_rdata_reg;
    assign d_ready = d_ready_reg;
    assign d_err   = d_err_reg;
    assign i_rdata = i_rdata_reg;
    assign i_ready = i_ready_reg;
    assign i_err   = i_err_reg;

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Directed bench for sys_bus_interconnect: latency, arbitration, decode
// miss, timeout, overlapping decode and reset abort.
module tb_sys_bus_interconnect;

    localparam int NS = 8;
    localparam int DW = 32;
    // slave0 0x0, slave1 0x1 (mask F), slave2 0x2, slave3 0x10 (mask FF), slaves4-7 0x4-0x7
    localparam logic [NS*32-1:0] BASE = {32'h7000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
                                         32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                         32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              d_req, d_we;
    logic [31:0]       d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic [DW-1:0]     d_rdata;
    logic              d_ready, d_err;
    logic              i_req;
    logic [31:0]       i_addr;
    logic [DW-1:0]     i_rdata;
    logic              i_ready, i_err;
    logic [NS-1:0]     s_req;
    logic              s_we;
    logic [31:0]       s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_be;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS-1:0]     s_ready;

    int checks = 0;
    int errors = 0;
    logic seen;

    sys_bus_interconnect #(
        .NUM_SLAVES (NS),
        .DW         (DW),
        .SLAVE_BASE (BASE),
        .SLAVE_MASK (MASK),
        .TIMEOUT    (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_be    (d_be),
        .d_rdata (d_rdata),
        .d_ready (d_ready),
        .d_err   (d_err),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .i_err   (i_err),
        .s_req   (s_req),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_be    (s_be),
        .s_rdata (s_rdata),
        .s_ready (s_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        i_req = 0; i_addr = '0; s_rdata = '0; s_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("reset_s_req",   s_req,   0);
        chk("reset_d_ready", d_ready, 0);
        chk("reset_i_ready", i_ready, 0);
        chk("reset_d_rdata", d_rdata, 0);
        chk("reset_s_addr",  s_addr,  0);
        chk("reset_d_err",   d_err,   0);

        // Data read to slave 2, s_ready on cycle 1
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h2000_0010; d_be = 4'hF;
        s_rdata[2*32 +: 32] = 32'hDEAD_BEEF;
        @(negedge clk); chk("t1_c0_s_req", s_req, 0);
        tick(); s_ready = 8'h04;
        @(negedge clk);
        chk("t1_c1_s_req",   s_req,   8'h04);
        chk("t1_c1_s_addr",  s_addr,  32'h2000_0010);
        chk("t1_c1_d_ready", d_ready, 0);
        tick(); s_ready = 8'h00; d_req = 0;
        @(negedge clk);
        chk("t1_c2_d_ready", d_ready, 1);
        chk("t1_c2_d_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("t1_c2_d_err",   d_err,   0);
        chk("t1_c2_s_req",   s_req,   0);
        tick();
        @(negedge clk);
        chk("t1_c3_d_ready", d_ready, 0);
        chk("t1_c3_d_hold",  d_rdata, 32'hDEAD_BEEF);

        // Simultaneous requests after reset: data first, then fetch, twice
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h2000_0000; d_be = 4'h3; d_wdata = 32'h0000_CAFE;
        i_req = 1; i_addr = 32'h0000_0100; s_ready = 8'hFF;
        s_rdata[0*32 +: 32] = 32'h1111_0000;
        s_rdata[2*32 +: 32] = 32'h2222_0000;
        tick();
        @(negedge clk);
        chk("t2_c1_s_req", s_req, 8'h04);
        chk("t2_c1_s_we",  s_we,  1);
        chk("t2_c1_s_be",  s_be,  4'h3);
        chk("t2_c1_s_wdata", s_wdata, 32'h0000_CAFE);
        tick(); d_req = 0;
        @(negedge clk);
        chk("t2_c2_d_ready", d_ready, 1);
        chk("t2_c2_i_ready", i_ready, 0);
        chk("t2_c2_d_rdata", d_rdata, 32'h2222_0000);
        tick();
        @(negedge clk); chk("t2_c3_i_ready", i_ready, 0);
        tick();
        @(negedge clk);
        chk("t2_c4_s_req",  s_req,  8'h01);
        chk("t2_c4_s_we",   s_we,   0);
        chk("t2_c4_s_be",   s_be,   4'hF);
        chk("t2_c4_s_addr", s_addr, 32'h0000_0100);
        tick(); i_req = 0;
        @(negedge clk);
        chk("t2_c5_i_ready", i_ready, 1);
        chk("t2_c5_i_rdata", i_rdata, 32'h1111_0000);
        chk("t2_c5_i_err",   i_err,   0);
        tick(); d_req = 1; i_req = 1; d_we = 0;
        tick();
        @(negedge clk); chk("t2b_c7_s_req", s_req, 8'h04);
        tick(); d_req = 0;
        @(negedge clk); chk("t2b_c8_d_ready", d_ready, 1);
        tick();
        tick();
        @(negedge clk); chk("t2b_c10_s_req", s_req, 8'h01);
        tick(); i_req = 0;
        @(negedge clk); chk("t2b_c11_i_ready", i_ready, 1);

        // Timeout: slave 4 never ready
        tick(); s_ready = 8'h00;
        d_req = 1; d_we = 0; d_addr = 32'h4000_0000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            @(negedge clk); chk($sformatf("t4_c%0d_s_req", c), s_req, 8'h10);
        end
        tick(); d_req = 0;
        @(negedge clk);
        chk("t4_s_req_drop", s_req,   0);
        chk("t4_d_ready",    d_ready, 1);
        chk("t4_d_err",      d_err,   1);
        chk("t4_d_rdata",    d_rdata, 0);

        // Write to unmapped address
        tick();
        d_req = 1; d_we = 1; d_addr = 32'hF000_0000; d_wdata = 32'h1234_5678;
        @(negedge clk); chk("t3_c0_s_req", s_req, 0);
        tick(); d_req = 0;
        @(negedge clk);
        chk("t3_c1_d_ready", d_ready, 1);
        chk("t3_c1_d_err",   d_err,   1);
        chk("t3_c1_s_req",   s_req,   0);
        tick();
        @(negedge clk); chk("t3_c2_d_ready", d_ready, 0);

        // Address matching slaves 1 and 3
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h1000_0100; s_ready = 8'hFF;
        s_rdata[1*32 +: 32] = 32'h1111_AAAA;
        s_rdata[3*32 +: 32] = 32'h3333_BBBB;
        tick();
        @(negedge clk); chk("t5_s_req", s_req, 8'h02);
        tick(); d_req = 0;
        @(negedge clk);
        chk("t5_d_ready", d_ready, 1);
        chk("t5_d_rdata", d_rdata, 32'h1111_AAAA);
        chk("t5_d_err",   d_err,   0);

        // Reset pulsed mid-WAIT
        tick();
        s_ready = 8'h00; d_req = 1; d_we = 0; d_addr = 32'h4000_0000;
        tick();
        @(negedge clk); chk("t6_s_req_wait", s_req, 8'h10);
        #2 rst_n = 1'b0;
        #1 chk("t6_s_req_async", s_req, 0);
        d_req = 0;
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_ready) seen = 1'b1;
            tick();
        end
        chk("t6_no_ready_pulse", seen,  0);
        chk("t6_s_req_after",    s_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
